exu_issue_sched: RTL

//  In-order single-issue scheduler between decode and the execute units (ALU, pipelined MUL, iterative DIV).

---
 rtl/exu_issue_sched_pkg.sv | 28 ++
 rtl/exu_scoreboard.sv | 41 ++++
 rtl/exu_issue_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exu_issue_sched_pkg.sv
// Shared scheduler types: writeback source, DIV sequencer states and
// the per-slot writeback reservation entry.
package cpu_consts;

  localparam int unsigned MUL_LAT_DEFAULT = 3;
  localparam int unsigned REG_W           = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MUL  = 2'd2,
    WB_DIV  = 2'd3
  } wb_src_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_WB   = 2'd2
  } div_state_t;

  typedef struct packed {
    logic             v;
    logic             wr;
    wb_src_t          sel;
    logic [REG_W-1:0] rd;
  } resv_t;

endpackage

// File: rtl/exu_scoreboard.sv
// Destination-register scoreboard: one pending bit per architectural
// register, set at issue and cleared at writeback; x0 is never tracked.
module exu_scoreboard
  import cpu_consts::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_rd_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             rd_chk_i,
  output logic             hit_o,
  output logic             empty_o
);

  logic [NREG-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_rd_i] = 1'b0;
    if (set_en_i) sb_d[set_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  assign hit_o = ((rs1_i != '0) && sb_q[rs1_i]) ||
                 ((rs2_i != '0) && sb_q[rs2_i]) ||
                 (rd_chk_i && (rd_i != '0) && sb_q[rd_i]);
  assign empty_o = ~|sb_q;

endmodule

// File: rtl/exu_issue_sched.sv
// In-order single-issue scheduler for ALU / pipelined MUL / iterative DIV with
// a shared writeback slot. Define EXU_SCHED_PERF_EN to add stall counters.
module exu_issue_sched
  import cpu_consts::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned NREG    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic             dec_alu_i,
  input  logic             dec_mul_i,
  input  logic             dec_div_i,
  input  logic             dec_rf_wr_en_i,
  input  logic [REG_W-1:0] dec_rd_i,
  input  logic [REG_W-1:0] dec_rs1_i,
  input  logic [REG_W-1:0] dec_rs2_i,
  input  logic             dec_exc_valid_i,
  output logic             alu_issue_o,
  output logic             mul_issue_o,
  output logic             div_start_o,
  input  logic             div_done_i,
  output logic             div_ack_o,
  output logic             wb_valid_o,
  output logic [1:0]       wb_sel_o,
  output logic [REG_W-1:0] wb_rd_o,
`ifdef EXU_SCHED_PERF_EN
  output logic [31:0]      stall_raw_cnt_o,
  output logic [31:0]      stall_slot_cnt_o,
  output logic [31:0]      stall_div_cnt_o,
`endif
  output logic             exc_valid_o
);

  // resv_q[k] holds the writeback due k-1 cycles from now; resv_q[1] is this cycle's slot.
  resv_t [MUL_LAT:1] resv_q, resv_d;
  div_state_t        div_state_q, div_state_d;
  logic [REG_W-1:0]  div_rd_q;
  logic              div_wr_q;
  logic              exc_valid_q;

  logic sb_hit, sb_empty;
  logic raw_stall, slot_stall, div_stall, exc_stall;
  logic accept, unit_op;

  assign unit_op = ~dec_exc_valid_i & (dec_alu_i | dec_mul_i | dec_div_i);

  exu_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .set_en_i (accept & unit_op & dec_rf_wr_en_i),
    .set_rd_i (dec_rd_i),
    .clr_en_i (wb_valid_o),
    .clr_rd_i (wb_rd_o),
    .rs1_i    (dec_rs1_i),
    .rs2_i    (dec_rs2_i),
    .rd_i     (dec_rd_i),
    .rd_chk_i (dec_rf_wr_en_i),
    .hit_o    (sb_hit),
    .empty_o  (sb_empty)
  );

  // An ALU op lands in resv_d[1], which is fed by resv_q[2]; a MUL always
  // lands in the top slot, which the shift leaves empty.
  assign raw_stall  = sb_hit;
  assign slot_stall = ~dec_exc_valid_i & dec_alu_i & resv_q[2].v;
  assign div_stall  = ~dec_exc_valid_i & dec_div_i & (div_state_q != D_IDLE);
  assign exc_stall  = dec_exc_valid_i & (~sb_empty | (|resv_q));

  assign dec_ready_o = ~flush_i & ~(raw_stall | slot_stall | div_stall | exc_stall);
  assign accept      = dec_valid_i & dec_ready_o;

  assign alu_issue_o = accept & ~dec_exc_valid_i & dec_alu_i;
  assign mul_issue_o = accept & ~dec_exc_valid_i & dec_mul_i;
  assign div_start_o = accept & ~dec_exc_valid_i & dec_div_i;
  assign exc_valid_o = exc_valid_q;

  always_comb begin
    resv_t ent;
    resv_d = resv_q >> $bits(resv_t);
    ent    = '{v: 1'b1, wr: dec_rf_wr_en_i, sel: WB_ALU, rd: dec_rd_i};
    if (alu_issue_o) resv_d[1] = ent;
    if (mul_issue_o) begin
      ent.sel         = WB_MUL;
      resv_d[MUL_LAT] = ent;
    end
  end

  always_comb begin
    div_state_d = div_state_q;
    div_ack_o   = 1'b0;
    wb_valid_o  = 1'b0;
    wb_sel_o    = WB_NONE;
    wb_rd_o     = '0;
    if (resv_q[1].v && resv_q[1].wr) begin
      wb_valid_o = 1'b1;
      wb_sel_o   = resv_q[1].sel;
      wb_rd_o    = resv_q[1].rd;
    end
    case (div_state_q)
      D_IDLE: if (div_start_o) div_state_d = D_BUSY;
      D_BUSY: if (div_done_i)  div_state_d = D_WB;
      D_WB: begin
        // A claimed slot, even one without a register write, keeps DIV waiting.
        if (!resv_q[1].v) begin
          div_ack_o   = 1'b1;
          div_state_d = D_IDLE;
          if (div_wr_q) begin
            wb_valid_o = 1'b1;
            wb_sel_o   = WB_DIV;
            wb_rd_o    = div_rd_q;
          end
        end
      end
      default: div_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resv_q      <= '0;
      div_state_q <= D_IDLE;
      div_rd_q    <= '0;
      div_wr_q    <= 1'b0;
      exc_valid_q <= 1'b0;
    end else begin
      resv_q      <= resv_d;
      div_state_q <= div_state_d;
      exc_valid_q <= accept & dec_exc_valid_i;
      if (div_start_o) begin
        div_rd_q <= dec_rd_i;
        div_wr_q <= dec_rf_wr_en_i;
      end
    end
  end

`ifdef EXU_SCHED_PERF_EN
  logic [31:0] raw_cnt_q, slot_cnt_q, div_cnt_q;
  logic        stall_cyc;

  assign stall_cyc = dec_valid_i & ~dec_ready_o & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_cnt_q  <= '0;
      slot_cnt_q <= '0;
      div_cnt_q  <= '0;
    end else if (stall_cyc) begin
      if (raw_stall) begin
        if (raw_cnt_q != '1) raw_cnt_q <= raw_cnt_q + 32'd1;
      end else if (slot_stall) begin
        if (slot_cnt_q != '1) slot_cnt_q <= slot_cnt_q + 32'd1;
      end else if (div_stall) begin
        if (div_cnt_q != '1) div_cnt_q <= div_cnt_q + 32'd1;
      end
    end
  end

  assign stall_raw_cnt_o  = raw_cnt_q;
  assign stall_slot_cnt_o = slot_cnt_q;
  assign stall_div_cnt_o  = div_cnt_q;
`endif

endmodule
